fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the program counter and drives the instruction
//  memory read address. Captures the returned word into the IF/ID pipeline
//  register for the decoder. Handles decode-side stall and branch/jump redirect.
//  Instruction memory is byte-addressed, 32-bit little-endian, combinational read.
// PARAMETERS
//  RESET_PC   32'h0000_0004  PC value loaded on reset
//  NOP_INST   32'h0000_0013  bubble word (ADDI x0,x0,0) inserted on flush/reset
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  rst              in   1   synchronous, active-high reset
//  stall_i          in   1   decode not ready; hold PC and IF/ID
//  jump_flag_i      in   1   redirect request (taken branch / JAL / JALR)
//  jump_addr_i      in   32  redirect target
//  pc_o             out  32  instruction memory read address (= PC register)
//  inst_i           in   32  instruction word returned for pc_o, same cycle
//  id_inst_o        out  32  IF/ID instruction
//  id_pc_o          out  32  IF/ID PC of id_inst_o
//  id_valid_o       out  1   IF/ID holds a real instruction
//  misalign_o       out  1   (FETCH_MISALIGN_TRAP_EN only) misaligned redirect pulse
//  misalign_addr_o  out  32  (FETCH_MISALIGN_TRAP_EN only) raw offending target
// BEHAVIOUR
//  - Reset (rst=1 at edge): PC=RESET_PC, id_inst_o=NOP_INST, id_pc_o=0,
//    id_valid_o=0, misalign_o=0, misalign_addr_o=0. Overrides all other inputs.
//  - pc_o is the PC register directly; inst_i is sampled at the same edge that
//    advances PC. Latency: word at PC appears on id_inst_o one cycle later.
//  - Edge priority: rst > jump_flag_i > stall_i > advance.
//  - Advance: PC<=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); IF/ID<=
//    {inst_i, PC, valid=1}.
//  - Stall: PC and all IF/ID outputs hold unchanged.
//  - Redirect: PC<={jump_addr_i[31:2],2'b00}; IF/ID<={NOP_INST, 0, valid=0}.
//    Redirect during stall still takes effect (flush wins). Back-to-back
//    redirects each load their target; only the last one's target is fetched.
//  - First fetched instruction after reset release is valid on id_* one cycle
//    after the first non-reset, non-stall edge.
//  - inst_i captured verbatim; no decoding or X filtering in this block.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: misalign_* ports exist; redirect with
//  jump_addr_i[1:0]!=0 pulses misalign_o for exactly one cycle, latches
//  misalign_addr_o=jump_addr_i (held until next misaligned redirect or reset);
//  PC/IF/ID behave as a normal redirect (aligned target, bubble).
//  Not defined: ports absent; low two target bits silently cleared.
// STRUCTURE
//  - Shared defines include: InstAddrBus, InstBus widths, NOP_INST encoding,
//    RESET_PC default, ZeroWord.
//  - Sub-module if_id_reg: IF/ID register with hold and flush inputs; PC
//    register and next-PC mux stay in fetch_unit.
// TESTING
//  - Reset then free run, inst_i=mem model: pc_o=4,8,12,...; id_pc_o lags by 1
//    cycle, id_inst_o at pc 4 = 32'h002081B3, id_valid_o=1 from 2nd edge.
//  - stall_i=1 for 3 cycles at pc_o=16: pc_o stays 16, id_* frozen; resumes 20.
//  - jump_flag_i=1, jump_addr_i=32'h40 with stall_i=1: next pc_o=32'h40,
//    id_inst_o=32'h13, id_valid_o=0; following cycle id_pc_o=32'h40, valid=1.
//  - PC forced via redirect to 32'hFFFF_FFFC, run 2 cycles: pc_o=0 then 4.
//  - rst asserted mid-stall with pending redirect: pc_o=RESET_PC, id_valid_o=0.
//  - (macro on) redirect to 32'h42: pc_o=32'h40, misalign_o=1 one cycle,
//    misalign_addr_o=32'h42 held; (macro off) pc_o=32'h40, no ports.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, bubble encoding and reset defaults.
package fetch_unit_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstAddrBus-1:0] RESET_PC_DFLT = 32'h0000_0004;
  localparam logic [InstBus-1:0]     NOP_INST_ENC  = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0] ZeroWord      = '0;

  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: priority rst > flush (bubble) > hold > load.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [InstBus-1:0] NOP_INST = NOP_INST_ENC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  input  logic                   flush_i,
  input  logic [InstBus-1:0]     inst_i,
  input  logic [InstAddrBus-1:0] pc_i,
  output logic [InstBus-1:0]     id_inst_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic                   id_valid_o
);
  logic [InstBus-1:0]     inst_q, inst_d;
  logic [InstAddrBus-1:0] pc_q, pc_d;
  logic                   valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      inst_d  = NOP_INST;
      pc_d    = ZeroWord;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      inst_d  = inst_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= ZeroWord;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign id_inst_o  = inst_q;
  assign id_pc_o    = pc_q;
  assign id_valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC mux and IF/ID capture.
// Optional misaligned-redirect reporting under FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [InstBus-1:0]     NOP_INST = NOP_INST_ENC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_flag_i,
  input  logic [InstAddrBus-1:0] jump_addr_i,
  output logic [InstAddrBus-1:0] pc_o,
  input  logic [InstBus-1:0]     inst_i,
  output logic [InstBus-1:0]     id_inst_o,
  output logic [InstAddrBus-1:0] id_pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                   misalign_o,
  output logic [InstAddrBus-1:0] misalign_addr_o,
`endif
  output logic                   id_valid_o
);
  logic [InstAddrBus-1:0] pc_q, pc_d;

  // Redirect wins over stall so a flush is never lost behind a busy decoder.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (jump_flag_i)  pc_d = align_word(jump_addr_i);
    else if (stall_i) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (stall_i),
    .flush_i    (jump_flag_i),
    .inst_i     (inst_i),
    .pc_i       (pc_q),
    .id_inst_o  (id_inst_o),
    .id_pc_o    (id_pc_o),
    .id_valid_o (id_valid_o)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                   mis_q, mis_d;
  logic [InstAddrBus-1:0] mis_addr_q, mis_addr_d;

  always_comb begin
    mis_d      = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
    mis_addr_d = mis_d ? jump_addr_i : mis_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q      <= 1'b0;
      mis_addr_q <= ZeroWord;
    end else begin
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a cycle-level behavioural model. Honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall_i, jump_flag_i;
  logic [31:0] jump_addr_i, pc_o, inst_i, id_inst_o, id_pc_o;
  logic        id_valid_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural expectation
  logic [31:0] m_pc, m_inst, m_idpc, m_maddr;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .pc_o        (pc_o),
    .inst_i      (inst_i),
    .id_inst_o   (id_inst_o),
    .id_pc_o     (id_pc_o),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o),
`endif
    .id_valid_o  (id_valid_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd4) return 32'h002081B3;
    return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  always_comb inst_i = mem_word(pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pc", pc_o, m_pc);
    chk("id_inst", id_inst_o, m_inst);
    chk("id_pc", id_pc_o, m_idpc);
    chk("id_valid", {31'd0, id_valid_o}, {31'd0, m_valid});
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    chk("misalign_addr", misalign_addr_o, m_maddr);
`endif
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1ns later.
  task automatic cycle(input logic r, input logic s, input logic j, input logic [31:0] a);
    rst = r; stall_i = s; jump_flag_i = j; jump_addr_i = a;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h4; m_inst = 32'h13; m_idpc = 0; m_valid = 0; m_mis = 0; m_maddr = 0;
    end else if (j) begin
      m_mis = (a % 4) != 0;
      if (m_mis) m_maddr = a;
      m_pc = a - (a % 4);
      m_inst = 32'h13; m_idpc = 0; m_valid = 0;
    end else begin
      m_mis = 0;
      if (!s) begin
        m_inst = mem_word(m_pc); m_idpc = m_pc; m_valid = 1;
        m_pc = m_pc + 4;
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    rst = 1; stall_i = 0; jump_flag_i = 0; jump_addr_i = 0;
    m_pc = 0; m_inst = 0; m_idpc = 0; m_valid = 0; m_mis = 0; m_maddr = 0;
    @(negedge clk);

    // Reset state, with noisy inputs that reset must override
    cycle(1, 1, 1, 32'h123);
    cycle(1, 0, 0, 0);
    chk("rst_pc", pc_o, 32'h4);
    chk("rst_inst", id_inst_o, 32'h13);

    // Free run from reset
    cycle(0, 0, 0, 0);
    chk("first_inst", id_inst_o, 32'h002081B3);
    chk("first_valid", {31'd0, id_valid_o}, 32'd1);
    chk("first_pc_next", pc_o, 32'h8);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("at16", pc_o, 32'd16);

    // Stall for 3 cycles at pc 16
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      chk("stall_pc", pc_o, 32'd16);
      chk("stall_idpc", id_pc_o, 32'd12);
    end
    cycle(0, 0, 0, 0);
    chk("resume_pc", pc_o, 32'd20);

    // Redirect during stall
    cycle(0, 1, 1, 32'h40);
    chk("jmp_pc", pc_o, 32'h40);
    chk("jmp_bubble", id_inst_o, 32'h13);
    chk("jmp_valid", {31'd0, id_valid_o}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("jmp_idpc", id_pc_o, 32'h40);
    chk("jmp_valid2", {31'd0, id_valid_o}, 32'd1);

    // Back-to-back redirects, then wrap at the top of the address space
    cycle(0, 0, 1, 32'h100);
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap0", pc_o, 32'h0);
    chk("wrap_idpc", id_pc_o, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap4", pc_o, 32'h4);

    // Reset beats a stalled pending redirect
    cycle(0, 1, 0, 0);
    cycle(1, 1, 1, 32'h80);
    chk("rst_mid_pc", pc_o, 32'h4);
    chk("rst_mid_valid", {31'd0, id_valid_o}, 32'd0);

    // Misaligned target
    cycle(0, 0, 1, 32'h42);
    chk("mis_pc", pc_o, 32'h40);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_addr", misalign_addr_o, 32'h42);
`endif
    cycle(0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_clear", {31'd0, misalign_o}, 32'd0);
    chk("mis_hold", misalign_addr_o, 32'h42);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, j;
      logic [31:0] a;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      j = ($urandom_range(0, 99) < 15);
      a = $urandom;
      cycle(r, s, j, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
